rename_ctrl: RTL and testbench
==============================

# rename_ctrl

Rename-stage controller for the RAT/PRF free-list datapath. Each cycle it decides how many decoded instructions, an in-order prefix of the N decode slots, may be renamed. The decision uses a registered count of free physical registers and the ROB space reported by the ROB. After a nuke it sequences a fixed recovery window, during which the RAT is reloaded from the RRAT and renaming is blocked. It gates the RAT/free-list write enable and drives the decode stall.

## Interface
Parameters:
- N, default 3, decode/rename slots per cycle
- PRF_ENTRIES, default 64, physical registers
- ROB_ENTRIES, default 32, ROB slots
- RECOVER_CYCLES, default 2, post-nuke blocked cycles (≥1)
- PRF_CNT_W = $clog2(PRF_ENTRIES+1); ROB_CNT_W = $clog2(ROB_ENTRIES+1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- nuke  in  1  branch-mispredict/exception flush
- dec_valid  in  N  slot holds an instruction; must be a contiguous prefix (slot 0 first)
- dec_dest_valid  in  N  slot writes a non-zero architectural destination; ignored where dec_valid=0
- rob_free_cnt  in  ROB_CNT_W  free ROB slots this cycle
- free_vector_from_rrat  in  PRF_ENTRIES  PRF entries released by retirement this cycle
- rrat_free_cnt  in  PRF_CNT_W  popcount of the RRAT free list; loaded on nuke
- rename_accept  out  N  prefix mask of slots renamed this cycle
- dec_stall  out  1  some valid slot was not accepted
- rat_we  out  1  RAT/free-list update enable
- free_cnt  out  PRF_CNT_W  registered free-PRF count
- recovering  out  1  state == RECOVER

## Operation
- State machine with two states, RUN and RECOVER. Reset state is RUN.
- Acceptance is combinational. Slot i is accepted iff all of the following hold:
  - state == RUN and nuke == 0
  - dec_valid[i] == 1
  - slots 0..i-1 are all accepted
  - the number of dest-valid slots in 0..i is ≤ free_cnt
  - i+1 ≤ rob_free_cnt
- alloc = number of accepted slots with dec_dest_valid set. freed = popcount(free_vector_from_rrat).
- Free-count update by condition:
  - RUN, no nuke: free_cnt_next = free_cnt − alloc + freed.
  - RECOVER, no nuke: free_cnt_next = free_cnt + freed.
  - nuke (either state): free_cnt_next = rrat_free_cnt, and freed is ignored because rrat_free_cnt already includes it.
- Arithmetic is done at PRF_CNT_W+1 bits. A result above PRF_ENTRIES is a simulation assertion error; RTL clamps it to PRF_ENTRIES. An underflow cannot occur by construction.
- dec_stall = |(dec_valid & ~rename_accept).
- rat_we = (state == RUN) & ~nuke.
- Transitions:
  - Any state + nuke → RECOVER, with rcnt loaded to RECOVER_CYCLES−1.
  - RECOVER, rcnt == 0, no nuke → RUN.
  - RECOVER, rcnt != 0, no nuke → stay in RECOVER, rcnt decrements.
  - A nuke during RECOVER restarts the window.
- Reset values:
  - free_cnt = PRF_ENTRIES
  - state = RUN, recovering = 0
  - rcnt = 0
  - stall counter = 0 (when compiled in)
  - All combinational outputs follow from these.

## Timing
- Acceptance, dec_stall and rat_we are valid in the same cycle as their inputs. There are no registers in that path.
- free_cnt reflects a cycle's allocations and frees on the next rising edge, giving one-cycle latency.
- A nuke in cycle T:
  - forces rename_accept = 0 and rat_we = 0 in cycle T
  - recovering = 1 in cycles T+1 through T+RECOVER_CYCLES
  - renaming may resume at cycle T+RECOVER_CYCLES+1
- Assertion of reset clears all state immediately, asynchronously, including mid-RECOVER. Release is sampled at the next clock edge.
- The decode handshake is valid/stall. Slots that are not accepted must be re-presented, shifted to slot 0, in a later cycle. This block does not hold them.

## Configuration
- RENAME_CTRL_PERF_EN defined:
  - adds output port stall_cycles, out, 32 bits
  - counts cycles with dec_stall=1 or recovering=1
  - saturates at 2^32−1
  - cleared only by reset, not by nuke
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use N=3, PRF_ENTRIES=64, ROB_ENTRIES=32, RECOVER_CYCLES=2.

1. Reset, then release. Drive dec_valid=3'b111, dec_dest_valid=3'b111, rob_free_cnt=32 → rename_accept=3'b111, dec_stall=0; free_cnt=61 next cycle.
2. free_cnt=2, dec_valid=3'b111, dec_dest_valid=3'b111 → rename_accept=3'b011, dec_stall=1, free_cnt=0 next. In the following cycle, with a zero free vector and dec_dest_valid[0]=1 → rename_accept=3'b000.
3. free_cnt=0, dec_valid=3'b111, dec_dest_valid=3'b000, rob_free_cnt=1 → rename_accept=3'b001, dec_stall=1, free_cnt stays 0.
4. free_cnt=10; accept 2 dest slots while free_vector_from_rrat has 3 bits set → free_cnt=11 next cycle.
5. Nuke with rrat_free_cnt=40 and the free vector holding 5 bits in the same cycle:
   - that cycle: rename_accept=0, rat_we=0
   - next cycle: free_cnt=40, recovering=1 for 2 cycles, then RUN
   - a second nuke in the first RECOVER cycle extends recovering to 3 cycles total
6. Assert reset asynchronously during RECOVER with free_cnt=17 → before the next clock edge: free_cnt=64, recovering=0, stall_cycles=0 (with RENAME_CTRL_PERF_EN defined).

Source files
------------

// File: rtl/rename_ctrl.sv
// rename_ctrl: rename-stage controller for the RAT/PRF free-list datapath.
// Each cycle it accepts an in-order prefix of the decode slots, limited by a
// registered free-PRF count and by the ROB space reported by the ROB. After a
// nuke it blocks renaming for a fixed recovery window while the RAT reloads
// from the RRAT.
//
// Optional feature macro: RENAME_CTRL_PERF_EN adds the stall_cycles output.
//
// Ports:
//   clock                  in   rising-edge clock
//   reset                  in   asynchronous active-low reset
//   nuke                   in   mispredict/exception flush
//   dec_valid[N]           in   valid slots (contiguous prefix from slot 0)
//   dec_dest_valid[N]      in   slot writes a non-zero architectural dest
//   rob_free_cnt           in   free ROB slots this cycle
//   free_vector_from_rrat  in   PRF entries released by retirement
//   rrat_free_cnt          in   RRAT free-list popcount, loaded on nuke
//   rename_accept[N]       out  prefix mask of slots renamed this cycle
//   dec_stall              out  some valid slot was not accepted
//   rat_we                 out  RAT/free-list update enable
//   free_cnt               out  registered free-PRF count
//   recovering             out  controller is in the recovery window
//   stall_cycles[32]       out  (RENAME_CTRL_PERF_EN) saturating stall count
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_RUN     | normal renaming
// ST_RECOVER | post-nuke window, RAT reload from RRAT, no rename

module rename_ctrl #(
    parameter int N              = 3,
    parameter int PRF_ENTRIES    = 64,
    parameter int ROB_ENTRIES    = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int PRF_CNT_W      = $clog2(PRF_ENTRIES + 1),
    parameter int ROB_CNT_W      = $clog2(ROB_ENTRIES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   nuke,
    input  logic [N-1:0]           dec_valid,
    input  logic [N-1:0]           dec_dest_valid,
    input  logic [ROB_CNT_W-1:0]   rob_free_cnt,
    input  logic [PRF_ENTRIES-1:0] free_vector_from_rrat,
    input  logic [PRF_CNT_W-1:0]   rrat_free_cnt,
    output logic [N-1:0]           rename_accept,
    output logic                   dec_stall,
    output logic                   rat_we,
    output logic [PRF_CNT_W-1:0]   free_cnt,
    output logic                   recovering
`ifdef RENAME_CTRL_PERF_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    // One extra bit so free + freed can be range-checked before clamping.
    localparam int CW     = PRF_CNT_W + 1;
    localparam int RCNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    logic [0:0]           state_q, state_d;
    logic [RCNT_W-1:0]    rcnt_q, rcnt_d;
    logic [PRF_CNT_W-1:0] free_cnt_q, free_cnt_d;

    logic                 run_ok;
    logic                 prefix_ok;
    logic [CW-1:0]        dest_sum;
    logic [CW-1:0]        alloc;
    logic [CW-1:0]        freed;
    logic [CW-1:0]        free_raw;

    always_comb begin
        run_ok        = (state_q == ST_RUN) & ~nuke;
        prefix_ok     = run_ok;
        dest_sum      = '0;
        alloc         = '0;
        rename_accept = '0;
        for (int i = 0; i < N; i++) begin
            dest_sum  = dest_sum + CW'(dec_valid[i] & dec_dest_valid[i]);
            prefix_ok = prefix_ok & dec_valid[i]
                      & (dest_sum <= {1'b0, free_cnt_q})
                      & (32'(i + 1) <= 32'(rob_free_cnt));
            rename_accept[i] = prefix_ok;
            alloc = alloc + CW'(prefix_ok & dec_dest_valid[i]);
        end
    end

    always_comb begin
        freed = '0;
        for (int i = 0; i < PRF_ENTRIES; i++) begin
            freed = freed + CW'(free_vector_from_rrat[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        free_raw = {1'b0, free_cnt_q};
        if (nuke) begin
            // rrat_free_cnt already accounts for this cycle's retirement frees.
            free_raw = {1'b0, rrat_free_cnt};
            state_d  = ST_RECOVER;
            rcnt_d   = RCNT_W'(RECOVER_CYCLES - 1);
        end else if (state_q == ST_RUN) begin
            free_raw = {1'b0, free_cnt_q} - alloc + freed;
        end else begin
            free_raw = {1'b0, free_cnt_q} + freed;
            if (rcnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                rcnt_d = rcnt_q - RCNT_W'(1);
            end
        end
        free_cnt_d = (free_raw > CW'(PRF_ENTRIES)) ? PRF_CNT_W'(PRF_ENTRIES)
                                                    : free_raw[PRF_CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            rcnt_q     <= '0;
            free_cnt_q <= PRF_CNT_W'(PRF_ENTRIES);
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    // Overflow means more registers were returned than exist: upstream bug.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (free_raw <= CW'(PRF_ENTRIES))
                else $error("rename_ctrl: free count overflow %0d", free_raw);
        end
    end

    assign dec_stall  = |(dec_valid & ~rename_accept);
    assign rat_we     = (state_q == ST_RUN) & ~nuke;
    assign free_cnt   = free_cnt_q;
    assign recovering = (state_q == ST_RECOVER);

`ifdef RENAME_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((dec_stall | recovering) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_rename_ctrl.sv
module tb_rename_ctrl;

    logic        clock;
    logic        reset;
    logic        nuke;
    logic [2:0]  dec_valid;
    logic [2:0]  dec_dest_valid;
    logic [5:0]  rob_free_cnt;
    logic [63:0] free_vector_from_rrat;
    logic [6:0]  rrat_free_cnt;
    logic [2:0]  rename_accept;
    logic        dec_stall;
    logic        rat_we;
    logic [6:0]  free_cnt;
    logic        recovering;
`ifdef RENAME_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int vectors    = 0;
    int miscompares = 0;

    rename_ctrl #(
        .N(3), .PRF_ENTRIES(64), .ROB_ENTRIES(32), .RECOVER_CYCLES(2)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .nuke                  (nuke),
        .dec_valid             (dec_valid),
        .dec_dest_valid        (dec_dest_valid),
        .rob_free_cnt          (rob_free_cnt),
        .free_vector_from_rrat (free_vector_from_rrat),
        .rrat_free_cnt         (rrat_free_cnt),
        .rename_accept         (rename_accept),
        .dec_stall             (dec_stall),
        .rat_we                (rat_we),
        .free_cnt              (free_cnt),
        .recovering            (recovering)
`ifdef RENAME_CTRL_PERF_EN
        ,
        .stall_cycles          (stall_cycles)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        nuke = 1'b0;
        dec_valid = 3'b000;
        dec_dest_valid = 3'b000;
        rob_free_cnt = 6'd0;
        free_vector_from_rrat = 64'd0;
        rrat_free_cnt = 7'd0;
        #1 reset = 1'b0;
        #1;
        chk("rst_free_cnt", free_cnt, 64);
        chk("rst_recovering", recovering, 0);
        chk("rst_accept", rename_accept, 3'b000);
        chk("rst_stall", dec_stall, 0);
        chk("rst_rat_we", rat_we, 1);
        @(negedge clock);
        reset = 1'b1;

        // 1: full accept from reset
        cyc();
        dec_valid = 3'b111; dec_dest_valid = 3'b111; rob_free_cnt = 6'd32;
        #1;
        chk("t1_accept", rename_accept, 3'b111);
        chk("t1_stall", dec_stall, 0);
        chk("t1_rat_we", rat_we, 1);
        cyc();
        chk("t1_free_cnt", free_cnt, 61);

        // Nuke to load free_cnt=2
        nuke = 1'b1; rrat_free_cnt = 7'd2;
        #1;
        chk("n2_accept", rename_accept, 3'b000);
        chk("n2_rat_we", rat_we, 0);
        chk("n2_stall", dec_stall, 1);
        cyc();
        nuke = 1'b0;
        chk("n2_recovering1", recovering, 1);
        chk("n2_free_cnt", free_cnt, 2);
        cyc();
        chk("n2_recovering2", recovering, 1);
        cyc();
        chk("n2_run", recovering, 0);

        // 2: free-count limited
        #1;
        chk("t2_accept", rename_accept, 3'b011);
        chk("t2_stall", dec_stall, 1);
        cyc();
        chk("t2_free_cnt", free_cnt, 0);
        dec_dest_valid = 3'b001;
        #1;
        chk("t2_accept_zero", rename_accept, 3'b000);
        chk("t2_stall_zero", dec_stall, 1);

        // 3: ROB limited, no dests needed
        cyc();
        dec_dest_valid = 3'b000; rob_free_cnt = 6'd1;
        #1;
        chk("t3_accept", rename_accept, 3'b001);
        chk("t3_stall", dec_stall, 1);
        cyc();
        chk("t3_free_cnt", free_cnt, 0);

        // Nuke to load free_cnt=10
        dec_valid = 3'b000; nuke = 1'b1; rrat_free_cnt = 7'd10;
        cyc();
        nuke = 1'b0;
        chk("n4_free_cnt", free_cnt, 10);
        cyc();
        cyc();
        chk("n4_run", recovering, 0);

        // 4: alloc 2, free 3
        dec_valid = 3'b011; dec_dest_valid = 3'b011; rob_free_cnt = 6'd32;
        free_vector_from_rrat = 64'h8000_0000_0001_0001;
        #1;
        chk("t4_accept", rename_accept, 3'b011);
        chk("t4_stall", dec_stall, 0);
        cyc();
        free_vector_from_rrat = 64'd0;
        chk("t4_free_cnt", free_cnt, 11);
        dec_valid = 3'b111; dec_dest_valid = 3'b000; rob_free_cnt = 6'd2;
        #1;
        chk("rob2_accept", rename_accept, 3'b011);
        chk("rob2_stall", dec_stall, 1);

        // 5: nuke with rrat=40, freed ignored
        cyc();
        dec_dest_valid = 3'b111; rob_free_cnt = 6'd32;
        nuke = 1'b1; rrat_free_cnt = 7'd40; free_vector_from_rrat = 64'h1F;
        #1;
        chk("t5_accept", rename_accept, 3'b000);
        chk("t5_rat_we", rat_we, 0);
        cyc();
        nuke = 1'b0; free_vector_from_rrat = 64'h3;
        chk("t5_free_cnt", free_cnt, 40);
        chk("t5_recovering1", recovering, 1);
        chk("t5_accept_rec", rename_accept, 3'b000);
        chk("t5_rat_we_rec", rat_we, 0);
        cyc();
        free_vector_from_rrat = 64'd0;
        chk("t5_recovering2", recovering, 1);
        chk("t5_free_rec", free_cnt, 42);
        cyc();
        chk("t5_run", recovering, 0);
        chk("t5_accept_run", rename_accept, 3'b111);
        chk("t5_rat_we_run", rat_we, 1);

        // 5b: second nuke in first RECOVER cycle
        dec_valid = 3'b000; nuke = 1'b1; rrat_free_cnt = 7'd30;
        cyc();
        chk("t5b_rec1", recovering, 1);
        chk("t5b_free30", free_cnt, 30);
        rrat_free_cnt = 7'd25;
        cyc();
        nuke = 1'b0;
        chk("t5b_rec2", recovering, 1);
        chk("t5b_free25", free_cnt, 25);
        cyc();
        chk("t5b_rec3", recovering, 1);
        cyc();
        chk("t5b_run", recovering, 0);

        // 6: async reset mid-RECOVER
        nuke = 1'b1; rrat_free_cnt = 7'd17;
        cyc();
        nuke = 1'b0;
        chk("t6_pre_free", free_cnt, 17);
        chk("t6_pre_rec", recovering, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_free_cnt", free_cnt, 64);
        chk("t6_recovering", recovering, 0);
`ifdef RENAME_CTRL_PERF_EN
        chk("t6_stall_cycles", stall_cycles, 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
